vram_arbiter: RTL and testbench

Owns the external video SRAM port and shares it between two requesters: the VDP line fetcher, which copies one scanline of pixel words from SRAM into the 512x32 line buffer, and a host port (CPU bridge or flash loader) doing single-word reads and writes. It sits beside `vdp` in the video clock domain. It drives the SRAM address, data and strobe pins and the line buffer write port.

---
 rtl/vram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video SRAM port arbiter: the scanline fetcher (SRAM -> 512x32 line buffer) and a
// single-word host port share one SRAM. Every output comes straight from a register.
module vram_arbiter #(
    parameter int LINE_PAIRS = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [17:0] fetch_base,
    input  logic        fetch_bank,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        fetch_overrun,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [17:0] host_adr,
    input  logic [15:0] host_dat_i,
    output logic [15:0] host_dat_o,
    output logic        host_ack,
    output logic [17:0] v_adr,
    output logic [15:0] v_dat_o,
    input  logic [15:0] v_dat_i,
    output logic        v_oe_sram,
    output logic        v_we,
    output logic        v_oe_pin,
    output logic [8:0]  lbw_adr,
    output logic [31:0] lbw_dat,
    output logic        lbw_we
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        HREAD = 3'd3,
        HW1   = 3'd4,
        HW2   = 3'd5,
        HACK  = 3'd6
    } state_t;

    localparam logic [8:0] LAST_WORD = 9'(2 * LINE_PAIRS - 1);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        bank_q, bank_d;
    logic [15:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic [17:0] pend_base_q, pend_base_d;
    logic        pend_bank_q, pend_bank_d;

    logic        busy_d, done_d, overrun_d, ack_d;
    logic [15:0] hdat_d;
    logic [17:0] vadr_d;
    logic [15:0] vdat_d;
    logic        oe_sram_d, we_d, oe_pin_d;
    logic [8:0]  lbw_adr_d;
    logic [31:0] lbw_dat_d;
    logic        lbw_we_d;
    logic        arb;
    logic        start_new;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_base_d = pend_base_q;
        pend_bank_d = pend_bank_q;
        done_d      = 1'b0;
        overrun_d   = fetch_start & fetch_busy;
        ack_d       = 1'b0;
        hdat_d      = host_dat_o;
        vadr_d      = v_adr;
        vdat_d      = v_dat_o;
        oe_sram_d   = 1'b0;
        we_d        = 1'b0;
        oe_pin_d    = 1'b0;
        lbw_adr_d   = lbw_adr;
        lbw_dat_d   = lbw_dat;
        lbw_we_d    = 1'b0;
        arb         = 1'b0;
        start_new   = fetch_start & ~fetch_busy;

        case (state_q)
            IDLE, DRAIN, HACK: arb = 1'b1;
            FETCH: begin
                // v_dat_i holds word cnt_q this cycle; odd words complete a pair
                if (!cnt_q[0]) begin
                    hold_d = v_dat_i;
                end else begin
                    lbw_we_d  = 1'b1;
                    lbw_dat_d = {v_dat_i, hold_q};
                    lbw_adr_d = {bank_q, cnt_q[8:1]};
                end
                if (cnt_q == LAST_WORD) begin
                    state_d = DRAIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 9'd1;
                    vadr_d    = v_adr + 18'd1;
                    oe_sram_d = 1'b1;
                end
            end
            HREAD: begin
                hdat_d  = v_dat_i;
                ack_d   = 1'b1;
                state_d = HACK;
            end
            HW1: begin
                state_d  = HW2;
                oe_pin_d = 1'b1;
                we_d     = 1'b1;
            end
            HW2: begin
                state_d = HACK;
                ack_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (arb) begin
            state_d = IDLE;
            if (pend_q) begin
                state_d   = FETCH;
                vadr_d    = pend_base_q;
                bank_d    = pend_bank_q;
                cnt_d     = 9'd0;
                oe_sram_d = 1'b1;
                pend_d    = 1'b0;
            end else if (start_new) begin
                state_d   = FETCH;
                vadr_d    = fetch_base;
                bank_d    = fetch_bank;
                cnt_d     = 9'd0;
                oe_sram_d = 1'b1;
            end else if (host_req && state_q != HACK) begin
                // HACK ignores host_req so the requester sees ack before a regrant
                vadr_d = host_adr;
                if (host_we) begin
                    state_d  = HW1;
                    vdat_d   = host_dat_i;
                    oe_pin_d = 1'b1;
                end else begin
                    state_d   = HREAD;
                    oe_sram_d = 1'b1;
                end
            end
        end else if (start_new) begin
            pend_d      = 1'b1;
            pend_base_d = fetch_base;
            pend_bank_d = fetch_bank;
        end

        busy_d = (state_d == FETCH) | (state_d == DRAIN) | pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 9'd0;
            bank_q        <= 1'b0;
            hold_q        <= 16'd0;
            pend_q        <= 1'b0;
            pend_base_q   <= 18'd0;
            pend_bank_q   <= 1'b0;
            fetch_busy    <= 1'b0;
            fetch_done    <= 1'b0;
            fetch_overrun <= 1'b0;
            host_dat_o    <= 16'd0;
            host_ack      <= 1'b0;
            v_adr         <= 18'd0;
            v_dat_o       <= 16'd0;
            v_oe_sram     <= 1'b0;
            v_we          <= 1'b0;
            v_oe_pin      <= 1'b0;
            lbw_adr       <= 9'd0;
            lbw_dat       <= 32'd0;
            lbw_we        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bank_q        <= bank_d;
            hold_q        <= hold_d;
            pend_q        <= pend_d;
            pend_base_q   <= pend_base_d;
            pend_bank_q   <= pend_bank_d;
            fetch_busy    <= busy_d;
            fetch_done    <= done_d;
            fetch_overrun <= overrun_d;
            host_dat_o    <= hdat_d;
            host_ack      <= ack_d;
            v_adr         <= vadr_d;
            v_dat_o       <= vdat_d;
            v_oe_sram     <= oe_sram_d;
            v_we          <= we_d;
            v_oe_pin      <= oe_pin_d;
            lbw_adr       <= lbw_adr_d;
            lbw_dat       <= lbw_dat_d;
            lbw_we        <= lbw_we_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with LINE_PAIRS=4 and a behavioural async SRAM
// whose unwritten words read back as the low 16 address bits.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [17:0] fetch_base;
    logic        fetch_bank;
    logic        fetch_busy, fetch_done, fetch_overrun;
    logic        host_req, host_we;
    logic [17:0] host_adr;
    logic [15:0] host_dat_i, host_dat_o;
    logic        host_ack;
    logic [17:0] v_adr;
    logic [15:0] v_dat_o, v_dat_i;
    logic        v_oe_sram, v_we, v_oe_pin;
    logic [8:0]  lbw_adr;
    logic [31:0] lbw_dat;
    logic        lbw_we;

    int nassert = 0;
    int nfail   = 0;
    logic checking = 1'b0;

    vram_arbiter #(.LINE_PAIRS(4)) dut (
        .clk(clk), .rst(rst),
        .fetch_start(fetch_start), .fetch_base(fetch_base), .fetch_bank(fetch_bank),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_overrun(fetch_overrun),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr),
        .host_dat_i(host_dat_i), .host_dat_o(host_dat_o), .host_ack(host_ack),
        .v_adr(v_adr), .v_dat_o(v_dat_o), .v_dat_i(v_dat_i),
        .v_oe_sram(v_oe_sram), .v_we(v_we), .v_oe_pin(v_oe_pin),
        .lbw_adr(lbw_adr), .lbw_dat(lbw_dat), .lbw_we(lbw_we)
    );

    always #5 clk = ~clk;

    // SRAM model: one remembered written word, everything else reads as its address
    logic        ov_vld = 1'b0;
    logic [17:0] ov_adr = 18'd0;
    logic [15:0] ov_dat = 16'd0;
    always @(posedge clk) begin
        if (v_we) begin
            ov_vld <= 1'b1;
            ov_adr <= v_adr;
            ov_dat <= v_dat_o;
        end
    end
    assign v_dat_i = (ov_vld && ov_adr == v_adr) ? ov_dat : v_adr[15:0];

    always @(negedge clk) begin
        if (checking) begin
            nassert++;
            if (v_oe_sram && v_oe_pin) begin
                nfail++;
                $display("FAIL oe_exclusive: v_oe_sram=%0b v_oe_pin=%0b, required not both 1",
                         v_oe_sram, v_oe_pin);
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nassert++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // flags = {busy, done, overrun, ack, oe_sram, oe_pin, we, lbw_we}
    typedef struct {
        logic        fs;
        logic [17:0] fbase;
        logic        fbank;
        logic        hreq;
        logic        hwe;
        logic [17:0] hadr;
        logic [15:0] hdat;
        logic [7:0]  flags;
        logic [17:0] vadr;
        logic [15:0] vdo;
        logic [8:0]  ladr;
        logic [31:0] ldat;
        logic [15:0] hdo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(
        input logic [31:0] fs, input logic [31:0] fbase, input logic [31:0] fbank,
        input logic [31:0] hreq, input logic [31:0] hwe, input logic [31:0] hadr,
        input logic [31:0] hdat, input logic [31:0] flags, input logic [31:0] vadr,
        input logic [31:0] vdo, input logic [31:0] ladr, input logic [31:0] ldat,
        input logic [31:0] hdo);
        vec_t r;
        r.fs = fs[0];       r.fbase = fbase[17:0]; r.fbank = fbank[0];
        r.hreq = hreq[0];   r.hwe = hwe[0];        r.hadr = hadr[17:0];
        r.hdat = hdat[15:0]; r.flags = flags[7:0]; r.vadr = vadr[17:0];
        r.vdo = vdo[15:0];  r.ladr = ladr[8:0];    r.ldat = ldat;
        r.hdo = hdo[15:0];
        return r;
    endfunction

    function automatic logic [98:0] all_outs();
        return {fetch_busy, fetch_done, fetch_overrun, host_dat_o, host_ack, v_adr, v_dat_o,
                v_oe_sram, v_we, v_oe_pin, lbw_adr, lbw_dat, lbw_we};
    endfunction

    initial begin
        rst = 1'b1;
        fetch_start = 1'b0; fetch_base = 18'd0; fetch_bank = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_adr = 18'd0; host_dat_i = 16'd0;

        // Fetch base 0x100 bank 1, with an overrun attempt in cycle 3
        tbl.push_back(row(1,'h100,1, 0,0,0,0, 'b1000_1000,'h100,0,0,0,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b1000_1000,'h101,0,0,0,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b1000_1001,'h102,0,'h100,'h01010100,0));
        tbl.push_back(row(1,'h20000,0, 0,0,0,0, 'b1010_1000,'h103,0,0,0,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b1000_1001,'h104,0,'h101,'h01030102,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b1000_1000,'h105,0,0,0,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b1000_1001,'h106,0,'h102,'h01050104,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b1000_1000,'h107,0,0,0,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b1100_0001,0,0,'h103,'h01070106,0));
        tbl.push_back(row(0,0,0,     0,0,0,0, 'b0000_0000,0,0,0,0,0));
        // Wrapping fetch from 0x3FFFE bank 0 beats a simultaneous held host write
        tbl.push_back(row(1,'h3FFFE,0, 1,1,'h42,'hBEEF, 'b1000_1000,'h3FFFE,0,0,0,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1000_1000,'h3FFFF,0,0,0,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1000_1001,'h00000,0,'h000,'hFFFFFFFE,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1000_1000,'h00001,0,0,0,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1000_1001,'h00002,0,'h001,'h00010000,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1000_1000,'h00003,0,0,0,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1000_1001,'h00004,0,'h002,'h00030002,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1000_1000,'h00005,0,0,0,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b1100_0001,0,0,'h003,'h00050004,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b0000_0100,'h42,'hBEEF,0,0,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b0000_0110,'h42,'hBEEF,0,0,0));
        tbl.push_back(row(0,0,0, 1,1,'h42,'hBEEF, 'b0001_0000,0,0,0,0,0));
        tbl.push_back(row(0,0,0, 0,0,0,0,         'b0000_0000,0,0,0,0,0));
        // Read back 0x42
        tbl.push_back(row(0,0,0, 1,0,'h42,0, 'b0000_1000,'h42,0,0,0,0));
        tbl.push_back(row(0,0,0, 1,0,'h42,0, 'b0001_0000,0,0,0,0,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0,    'b0000_0000,0,0,0,0,'hBEEF));
        // fetch_start during HW1: pending fetch starts after HACK
        tbl.push_back(row(0,0,0,      1,1,'h50,'h1234, 'b0000_0100,'h50,'h1234,0,0,'hBEEF));
        tbl.push_back(row(1,'h200,0,  1,1,'h50,'h1234, 'b1000_0110,'h50,'h1234,0,0,'hBEEF));
        tbl.push_back(row(0,0,0,      1,1,'h50,'h1234, 'b1001_0000,0,0,0,0,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1000,'h200,0,0,0,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1000,'h201,0,0,0,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1001,'h202,0,'h000,'h02010200,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1000,'h203,0,0,0,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1001,'h204,0,'h001,'h02030202,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1000,'h205,0,0,0,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1001,'h206,0,'h002,'h02050204,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1000_1000,'h207,0,0,0,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b1100_0001,0,0,'h003,'h02070206,'hBEEF));
        tbl.push_back(row(0,0,0, 0,0,0,0, 'b0000_0000,0,0,0,0,'hBEEF));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 128'(all_outs()), 128'd0);
        checking = 1'b1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            fetch_start = tbl[i].fs;   fetch_base = tbl[i].fbase; fetch_bank = tbl[i].fbank;
            host_req = tbl[i].hreq;    host_we = tbl[i].hwe;
            host_adr = tbl[i].hadr;    host_dat_i = tbl[i].hdat;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d flags", i),
                128'({fetch_busy, fetch_done, fetch_overrun, host_ack,
                      v_oe_sram, v_oe_pin, v_we, lbw_we}), 128'(tbl[i].flags));
            chk($sformatf("v%0d host_dat_o", i), 128'(host_dat_o), 128'(tbl[i].hdo));
            if (tbl[i].flags[3] || tbl[i].flags[2])
                chk($sformatf("v%0d v_adr", i), 128'(v_adr), 128'(tbl[i].vadr));
            if (tbl[i].flags[2])
                chk($sformatf("v%0d v_dat_o", i), 128'(v_dat_o), 128'(tbl[i].vdo));
            if (tbl[i].flags[0])
                chk($sformatf("v%0d lbw", i), 128'({lbw_adr, lbw_dat}),
                    128'({tbl[i].ladr, tbl[i].ldat}));
        end

        // Reset in cycle 3 of a fetch
        fetch_start = 1'b1; fetch_base = 18'h100; fetch_bank = 1'b1;
        host_req = 1'b0; host_we = 1'b0;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_cycle3_fetching", 128'({v_oe_sram, v_adr, fetch_busy}), 128'({1'b1, 18'h103, 1'b1}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outputs_zero", 128'(all_outs()), 128'd0);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_quiet c%0d", c),
                128'({lbw_we, fetch_done, fetch_busy, v_oe_sram}), 128'd0);
        end

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
